pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 115 +++++++++++
 tb/tb_pc_fetch.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: IF-stage PC register and IDLE/REQ/HOLD instruction-fetch FSM.
// Optional PC_MISALIGN_CHECK_EN blocks fetches from non-word-aligned PCs.
module pc_fetch (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        ready_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o,
`ifdef PC_MISALIGN_CHECK_EN
   output logic        misalign_o,
`endif
   output logic        valid_o
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, redir_pc_q, redir_pc_d;
   logic        valid_q, valid_d, redir_pend_q, redir_pend_d, start_ok;
`ifdef PC_MISALIGN_CHECK_EN
   logic        misalign_q, misalign_d;
   assign start_ok   = start_i & ~misalign_q;
   assign misalign_o = misalign_q;
`else
   assign start_ok   = start_i;
`endif
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      valid_d      = valid_q;
      redir_pc_d   = redir_pc_q;
      redir_pend_d = redir_pend_q;
      case (state_q)
         IDLE: begin
            if (flush_i) pc_d = pc_i;
            if (start_ok) state_d = REQ;
         end
         REQ: begin
            // a flush during an outstanding request is deferred until its ack
            if (imem_ack_i) begin
               redir_pend_d = 1'b0;
               if (flush_i) pc_d = pc_i;
               else if (redir_pend_q) pc_d = redir_pc_q;
               else begin
                  instr_d = imem_data_i;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            end else if (flush_i) begin
               redir_pc_d   = pc_i;
               redir_pend_d = 1'b1;
            end
         end
         HOLD: begin
            if (flush_i) begin
               pc_d    = pc_i;
               valid_d = 1'b0;
               state_d = REQ;
            end else if (ready_i && !stall_i) begin
               pc_d    = pc_i;
               valid_d = 1'b0;
               state_d = start_ok ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef PC_MISALIGN_CHECK_EN
      misalign_d = misalign_q;
      if (state_d == REQ && pc_d[1:0] != 2'b00) begin
         state_d      = IDLE;
         redir_pend_d = 1'b0;
         misalign_d   = 1'b1;
      end
`endif
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         instr_q      <= '0;
         valid_q      <= 1'b0;
         redir_pc_q   <= '0;
         redir_pend_q <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
         redir_pc_q   <= redir_pc_d;
         redir_pend_q <= redir_pend_d;
`ifdef PC_MISALIGN_CHECK_EN
         misalign_q   <= misalign_d;
`endif
      end
   end
   assign imem_req_o  = (state_q == REQ);
   assign imem_addr_o = pc_q;
   assign pc_o        = pc_q;
   assign pc_plus4_o  = pc_q + 32'd4;
   assign instr_o     = instr_q;
   assign valid_o     = valid_q;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed-vector bench for pc_fetch with hand-computed expectations.
module tb_pc_fetch;
   logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, flush_i = 1'b0;
   logic        stall_i = 1'b0, ready_i = 1'b0, imem_ack_i = 1'b0;
   logic [31:0] pc_i = '0, imem_data_i = '0;
   logic        imem_req_o, valid_o;
   logic [31:0] imem_addr_o, pc_o, pc_plus4_o, instr_o;
`ifdef PC_MISALIGN_CHECK_EN
   logic        misalign_o;
`endif
   int checks = 0, failures = 0;

   pc_fetch dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
      .flush_i(flush_i), .stall_i(stall_i), .ready_i(ready_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
      .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_o(instr_o),
`ifdef PC_MISALIGN_CHECK_EN
      .misalign_o(misalign_o),
`endif
      .valid_o(valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #3;
      check("rst_pc", pc_o, 32'h0);
      check("rst_valid", {31'b0, valid_o}, 32'h0);
      check("rst_req", {31'b0, imem_req_o}, 32'h0);
      tick();
      rst_i = 1'b1; start_i = 1'b1; imem_ack_i = 1'b1; imem_data_i = 32'h13; ready_i = 1'b1; pc_i = 32'h4;
      // three back-to-back fetches with zero-wait ack
      tick();
      check("f0_req", {31'b0, imem_req_o}, 32'h1);
      check("f0_addr", imem_addr_o, 32'h0);
      tick();
      check("f0_valid", {31'b0, valid_o}, 32'h1);
      check("f0_instr", instr_o, 32'h13);
      check("f0_pc", pc_o, 32'h0);
      tick();
      check("f1_addr", imem_addr_o, 32'h4);
      check("f1_novalid", {31'b0, valid_o}, 32'h0);
      pc_i = 32'h8;
      tick();
      check("f1_valid", {31'b0, valid_o}, 32'h1);
      tick();
      check("f2_addr", imem_addr_o, 32'h8);
      pc_i = 32'hC;
      tick();
      check("f2_valid", {31'b0, valid_o}, 32'h1);
      // stall in HOLD for three cycles
      stall_i = 1'b1; imem_ack_i = 1'b0; imem_data_i = 32'hBAD;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", pc_o, 32'h8);
         check("stall_instr", instr_o, 32'h13);
         check("stall_valid", {31'b0, valid_o}, 32'h1);
      end
      stall_i = 1'b0;
      tick();
      check("unstall_pc", pc_o, 32'hC);
      check("unstall_valid", {31'b0, valid_o}, 32'h0);
      // flush while request outstanding, ack two cycles later
      flush_i = 1'b1; pc_i = 32'h40;
      tick();
      check("fl_req", {31'b0, imem_req_o}, 32'h1);
      check("fl_addr_keep", imem_addr_o, 32'hC);
      flush_i = 1'b0; pc_i = 32'h44;
      tick();
      check("fl_addr_keep2", imem_addr_o, 32'hC);
      imem_ack_i = 1'b1; imem_data_i = 32'hDEAD;
      tick();
      check("fl_discard_valid", {31'b0, valid_o}, 32'h0);
      check("fl_new_addr", imem_addr_o, 32'h40);
      check("fl_still_req", {31'b0, imem_req_o}, 32'h1);
      imem_data_i = 32'h93;
      tick();
      check("fl_fetch_valid", {31'b0, valid_o}, 32'h1);
      check("fl_fetch_instr", instr_o, 32'h93);
      // flush in HOLD overrides ready_i=0; then PC wraparound
      flush_i = 1'b1; ready_i = 1'b0; pc_i = 32'hFFFF_FFFC;
      tick();
      check("wrap_pc", pc_o, 32'hFFFF_FFFC);
      check("wrap_plus4", pc_plus4_o, 32'h0);
      check("hold_flush_valid", {31'b0, valid_o}, 32'h0);
      flush_i = 1'b0; ready_i = 1'b1; pc_i = 32'h0; imem_data_i = 32'h13;
      tick();
      check("wrap_valid", {31'b0, valid_o}, 32'h1);
      imem_ack_i = 1'b0;
      tick();
      check("wrap_next_addr", imem_addr_o, 32'h0);
      check("wrap_next_req", {31'b0, imem_req_o}, 32'h1);
      // asynchronous reset mid-request
      #2 rst_i = 1'b0;
      #1;
      check("areset_req", {31'b0, imem_req_o}, 32'h0);
      check("areset_valid", {31'b0, valid_o}, 32'h0);
      tick();
      rst_i = 1'b1; start_i = 1'b0; imem_ack_i = 1'b1;
      tick();
      check("late_ack_req", {31'b0, imem_req_o}, 32'h0);
      check("late_ack_valid", {31'b0, valid_o}, 32'h0);
      imem_ack_i = 1'b0; flush_i = 1'b1; pc_i = 32'h80;
      tick();
      check("idle_flush_pc", pc_o, 32'h80);
      check("idle_flush_req", {31'b0, imem_req_o}, 32'h0);
`ifdef PC_MISALIGN_CHECK_EN
      pc_i = 32'h42; start_i = 1'b1;
      tick();
      check("mis_noreq", {31'b0, imem_req_o}, 32'h0);
      check("mis_flag", {31'b0, misalign_o}, 32'h1);
      flush_i = 1'b0;
      tick();
      check("mis_sticky", {31'b0, misalign_o}, 32'h1);
      check("mis_start_ignored", {31'b0, imem_req_o}, 32'h0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
